// File: rtl/dmux_dispatcher.sv
// dmux_dispatcher
//   Steers words from one valid/ready input to one of two output channels
//   (A or B). Each channel owns a one-entry holding register with its own
//   valid/ready handshake. The destination is either in_sel or a round-robin
//   pointer (rr_mode=1). A per-channel counter tracks delivered words.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_data/in_sel      input word and explicit destination (0=A, 1=B)
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   rr_mode             1 = round-robin steering, in_sel ignored
//   a_data/a_valid/a_ready   channel A output handshake
//   b_data/b_valid/b_ready   channel B output handshake
//   rr_ptr              next round-robin destination
//   cnt_a/cnt_b         wrapping counts of completed output handshakes
//
// Channel FSM (one per channel)
//   state | meaning
//   EMPTY | holding register free, valid=0
//   FULL  | holding register holds a word, valid=1

module dmux_dispatcher #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_mode,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             rr_ptr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t a_state;
  ch_state_t b_state;

  logic dest;
  logic dest_valid;
  logic dest_ready;
  logic accept;
  logic acc_a;
  logic acc_b;
  logic hs_a;
  logic hs_b;

  assign a_valid = (a_state == FULL);
  assign b_valid = (b_state == FULL);

  // Only the selected channel gates the input, so a stalled channel never
  // blocks words bound for the other one. Round-robin does not skip a
  // full channel; it waits for it.
  assign dest       = rr_mode ? rr_ptr : in_sel;
  assign dest_valid = dest ? b_valid : a_valid;
  assign dest_ready = dest ? b_ready : a_ready;
  assign in_ready   = ~dest_valid | dest_ready;

  assign accept = in_valid & in_ready;
  assign acc_a  = accept & ~dest;
  assign acc_b  = accept & dest;
  assign hs_a   = a_valid & a_ready;
  assign hs_b   = b_valid & b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
      a_data  <= '0;
      b_data  <= '0;
      rr_ptr  <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
    end else begin
      // A FULL channel only sees an accept when it is also draining, so
      // FULL stays FULL on a reload.
      case (a_state)
        EMPTY:   if (acc_a)          a_state <= FULL;
        FULL:    if (hs_a && !acc_a) a_state <= EMPTY;
        default:                     a_state <= EMPTY;
      endcase

      case (b_state)
        EMPTY:   if (acc_b)          b_state <= FULL;
        FULL:    if (hs_b && !acc_b) b_state <= EMPTY;
        default:                     b_state <= EMPTY;
      endcase

      if (acc_a) a_data <= in_data;
      if (acc_b) b_data <= in_data;

      if (accept && rr_mode) rr_ptr <= ~rr_ptr;

      if (hs_a) cnt_a <= cnt_a + 1'b1;
      if (hs_b) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmux_dispatcher.sv
module tb_dmux_dispatcher;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_mode;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        rr_ptr;
  logic [7:0]  cnt_a;
  logic [7:0]  cnt_b;

  dmux_dispatcher #(.WIDTH(16), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rr_mode  (rr_mode),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .rr_ptr   (rr_ptr),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: words expected on each channel, in delivery order
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        exp_rr = 1'b0;

  // ctl = {valid, sel, rr_mode, a_ready, b_ready}
  // ex  = {in_ready, a_valid, b_valid, rr_ptr} (outputs after the edge, in_ready before)
  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] d;
    logic [3:0]  ex;
    logic [7:0]  eca;
    logic [7:0]  ecb;
  } vec_t;

  vec_t vq[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic add(input logic [4:0] ctl, input logic [15:0] d, input logic [3:0] ex,
                     input logic [7:0] eca, input logic [7:0] ecb);
    vec_t v;
    v.ctl = ctl; v.d = d; v.ex = ex; v.eca = eca; v.ecb = ecb;
    vq.push_back(v);
  endtask

  // Drive one cycle; the bench model predicts in_ready from its own view of
  // channel occupancy and pushes accepted words onto the scoreboard.
  task automatic cyc(input logic v, input logic s, input logic [15:0] d, input logic rr,
                     input logic ar, input logic br, output logic got_ready);
    logic dst, full, drdy, er;
    in_valid = v; in_sel = s; in_data = d; rr_mode = rr; a_ready = ar; b_ready = br;
    #1;
    dst  = rr ? exp_rr : s;
    full = dst ? (qb.size() != 0) : (qa.size() != 0);
    drdy = dst ? br : ar;
    er   = !full || drdy;
    got_ready = in_ready;
    check("in_ready_model", 32'(in_ready), 32'(er));
    if (v && er) begin
      if (dst) qb.push_back(d);
      else     qa.push_back(d);
      if (rr) exp_rr = ~exp_rr;
    end
    @(posedge clk); #1;
    check("rr_ptr_model", 32'(rr_ptr), 32'(exp_rr));
  endtask

  task automatic rst_cycle(input logic ar, input logic br, input logic v);
    reset = 1'b1; a_ready = ar; b_ready = br; in_valid = v;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    qa.delete(); qb.delete(); exp_rr = 1'b0;
  endtask

  // output monitor: pops the scoreboard on each completed output handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid && a_ready) begin
        check("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) check("a_data", 32'(a_data), 32'(qa.pop_front()));
      end
      if (b_valid && b_ready) begin
        check("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) check("b_data", 32'(b_data), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    logic r;
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    rr_mode = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

    //   ctl(v s rr ar br)  data        ex(rdy av bv rp) cnt_a cnt_b
    add(5'b10010, 16'h1234, 4'b1100, 8'd0, 8'd0);
    add(5'b00010, 16'h0000, 4'b1000, 8'd1, 8'd0);
    add(5'b10000, 16'h1111, 4'b1100, 8'd1, 8'd0);
    add(5'b10000, 16'h2222, 4'b0100, 8'd1, 8'd0);
    add(5'b10010, 16'h2222, 4'b1100, 8'd2, 8'd0);
    add(5'b11000, 16'hBEEF, 4'b1110, 8'd2, 8'd0);
    add(5'b01001, 16'h0000, 4'b1100, 8'd2, 8'd1);
    add(5'b00010, 16'h0000, 4'b1000, 8'd3, 8'd1);
    add(5'b11111, 16'h0001, 4'b1101, 8'd3, 8'd1);
    add(5'b10111, 16'h0002, 4'b1010, 8'd4, 8'd1);
    add(5'b11111, 16'h0003, 4'b1101, 8'd4, 8'd2);
    add(5'b10111, 16'h0004, 4'b1010, 8'd5, 8'd2);
    add(5'b00111, 16'h0000, 4'b1000, 8'd5, 8'd3);
    add(5'b11101, 16'h0005, 4'b1101, 8'd5, 8'd3);
    add(5'b11101, 16'h0006, 4'b1110, 8'd5, 8'd3);
    add(5'b11101, 16'h0007, 4'b0100, 8'd5, 8'd4);
    add(5'b11101, 16'h0007, 4'b0100, 8'd5, 8'd4);
    add(5'b11111, 16'h0007, 4'b1101, 8'd6, 8'd4);
    add(5'b00011, 16'h0000, 4'b1001, 8'd7, 8'd4);
    add(5'b10011, 16'h0008, 4'b1101, 8'd7, 8'd4);
    add(5'b00011, 16'h0000, 4'b1001, 8'd8, 8'd4);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_rr_ptr", 32'(rr_ptr), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);

    foreach (vq[i]) begin
      cyc(vq[i].ctl[4], vq[i].ctl[3], vq[i].d, vq[i].ctl[2], vq[i].ctl[1], vq[i].ctl[0], r);
      check($sformatf("v%0d_in_ready", i), 32'(r), 32'(vq[i].ex[3]));
      check($sformatf("v%0d_a_valid", i), 32'(a_valid), 32'(vq[i].ex[2]));
      check($sformatf("v%0d_b_valid", i), 32'(b_valid), 32'(vq[i].ex[1]));
      check($sformatf("v%0d_rr_ptr", i), 32'(rr_ptr), 32'(vq[i].ex[0]));
      check($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(vq[i].eca));
      check($sformatf("v%0d_cnt_b", i), 32'(cnt_b), 32'(vq[i].ecb));
    end

    // counter wrap: 255 deliveries then one more
    rst_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b0, 16'(i + 256), 1'b0, 1'b1, 1'b0, r);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, r);
    check("wrap_cnt_a_255", 32'(cnt_a), 32'd255);
    cyc(1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0, r);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, r);
    check("wrap_cnt_a_0", 32'(cnt_a), 32'd0);
    check("wrap_a_valid", 32'(a_valid), 32'd0);

    // reset with both channels full and counters non-zero
    cyc(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b1, 1'b1, r);
    cyc(1'b1, 1'b1, 16'h00BB, 1'b0, 1'b1, 1'b1, r);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, r);
    check("pre_cnt_a", 32'(cnt_a), 32'd1);
    check("pre_cnt_b", 32'(cnt_b), 32'd1);
    cyc(1'b1, 1'b1, 16'h00C1, 1'b0, 1'b0, 1'b0, r);
    cyc(1'b1, 1'b0, 16'h00C2, 1'b1, 1'b0, 1'b0, r);
    check("pre_a_valid", 32'(a_valid), 32'd1);
    check("pre_b_valid", 32'(b_valid), 32'd1);
    check("pre_rr_ptr", 32'(rr_ptr), 32'd1);
    rst_cycle(1'b1, 1'b1, 1'b1);
    check("mid_rst_a_valid", 32'(a_valid), 32'd0);
    check("mid_rst_b_valid", 32'(b_valid), 32'd0);
    check("mid_rst_a_data", 32'(a_data), 32'd0);
    check("mid_rst_b_data", 32'(b_data), 32'd0);
    check("mid_rst_rr_ptr", 32'(rr_ptr), 32'd0);
    check("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
    a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cnt_a", 32'(cnt_a), 32'd0);

    check("a_sb_drained", 32'(qa.size()), 32'd0);
    check("b_sb_drained", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
